// File: rtl/lcd_text_writer.sv
// Character buffer plus full-screen refresh sequencer feeding the character-LCD driver handshake.
// Build option: define LCD_TEXT_CLEAR_EN to prefix every refresh with a display-clear command.
module lcd_text_writer #(
    parameter int unsigned COLS        = 16,
    parameter int unsigned LINES       = 2,
    parameter logic [6:0]  LINE2_ADDR  = 7'h40,
    parameter int unsigned ACK_TIMEOUT = 255,
    localparam int unsigned AW = (LINES * COLS > 1) ? $clog2(LINES * COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          lcd_busy,
    output logic          lcd_enable,
    output logic [9:0]    lcd_bus,
    output logic          active,
    output logic          done,
    output logic          error
);
    localparam int unsigned DEPTH = LINES * COLS;
    localparam int unsigned CW    = $clog2(COLS + 1);
    localparam int unsigned TW    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

`ifdef LCD_TEXT_CLEAR_EN
    localparam logic CLEAR_EN = 1'b1;
`else
    localparam logic CLEAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    char_mem [DEPTH];
    logic          line_q, line_d;
    logic [CW-1:0] col_q, col_d;     // 0 = address item, 1..COLS = character items
    logic          clr_q, clr_d;     // clear command still pending
    logic [TW-1:0] cnt_q, cnt_d;
    logic          en_d, active_d, done_d, error_d;
    logic [9:0]    bus_d;
    logic          last_item;
    logic [AW-1:0] rd_addr;

    // Character buffer: writable at any time, cleared to spaces on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                char_mem[i] <= 8'h20;
            end
        end else if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
            char_mem[wr_addr] <= wr_data;
        end
    end

    // State, item position and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            line_q     <= 1'b0;
            col_q      <= '0;
            clr_q      <= 1'b0;
            cnt_q      <= '0;
            lcd_enable <= 1'b0;
            lcd_bus    <= '0;
            active     <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            col_q      <= col_d;
            clr_q      <= clr_d;
            cnt_q      <= cnt_d;
            lcd_enable <= en_d;
            lcd_bus    <= bus_d;
            active     <= active_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

    // Next state; outputs are computed for the state being entered so they line up with it.
    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        col_d     = col_q;
        clr_d     = clr_q;
        cnt_d     = cnt_q;
        active_d  = active;
        done_d    = 1'b0;
        error_d   = error;
        last_item = !clr_q && (line_q == 1'(LINES - 1)) && (col_q == CW'(COLS));

        unique case (state_q)
            S_IDLE: begin
                // done is still high on the first idle cycle; a start there is dropped
                if (start && !done) begin
                    state_d  = S_WAIT_READY;
                    active_d = 1'b1;
                    error_d  = 1'b0;
                    line_d   = 1'b0;
                    col_d    = '0;
                    clr_d    = CLEAR_EN;
                end
            end
            S_WAIT_READY: begin
                if (!lcd_busy) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = TW'(1);
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (lcd_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q >= TW'(ACK_TIMEOUT - 1)) begin
                    error_d  = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!lcd_busy) begin
                    if (last_item) begin
                        done_d   = 1'b1;
                        active_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_ISSUE;
                        if (clr_q) begin
                            clr_d = 1'b0;
                        end else if (col_q == CW'(COLS)) begin
                            col_d  = '0;
                            line_d = line_q + 1'b1;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        en_d    = (state_d == S_ISSUE);
        rd_addr = (col_d == '0) ? '0 : AW'(32'(line_d) * COLS + 32'(col_d) - 32'd1);
        bus_d   = '0;
        if (en_d) begin
            if (clr_d) begin
                bus_d = 10'h001;
            end else if (col_d == '0) begin
                bus_d = {3'b001, line_d ? LINE2_ADDR : 7'h00};
            end else begin
                bus_d = {2'b10, char_mem[rd_addr]};
            end
        end
    end
endmodule

// File: tb/tb_lcd_text_writer.sv
// Bench for lcd_text_writer: busy-handshake driver model, expected-item queue and negedge monitor.
module tb_lcd_text_writer;
    localparam int unsigned COLS      = 16;
    localparam int unsigned LINES     = 2;
    localparam int unsigned DEPTH     = LINES * COLS;
    localparam int unsigned ACK_TO    = 255;
    localparam int          INIT_BUSY = 20;
    localparam int          DATA_TAG  = 32'h0001_0000;
`ifdef LCD_TEXT_CLEAR_EN
    localparam int N_ITEMS = int'(LINES * (COLS + 1)) + 1;
`else
    localparam int N_ITEMS = int'(LINES * (COLS + 1));
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       lcd_busy;
    logic       lcd_enable;
    logic [9:0] lcd_bus;
    logic       active, done, error;

    int         busy_cnt = 0;
    int         fixed_hold = 0;
    bit         no_ack = 1'b0;
    int         exp_q[$];
    logic [7:0] model_mem [DEPTH];
    int         checks = 0, errors = 0, pulses = 0, dones = 0;
    logic       prev_en = 1'b0;

    always #5 clk = ~clk;

    lcd_text_writer #(
        .COLS(COLS), .LINES(LINES), .LINE2_ADDR(7'h40), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .lcd_busy(lcd_busy), .lcd_enable(lcd_enable),
        .lcd_bus(lcd_bus), .active(active), .done(done), .error(error)
    );

    // Driver model: busy during init after reset, then busy for a few cycles after each request.
    always @(posedge clk) begin
        if (rst) busy_cnt <= INIT_BUSY;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (lcd_enable && !no_ack)
            busy_cnt <= (fixed_hold != 0) ? fixed_hold : int'($urandom_range(4, 1));
    end
    assign lcd_busy = (busy_cnt != 0);

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] resolve(input int e);
        if (e >= DATA_TAG) return {2'b10, model_mem[e - DATA_TAG]};
        return 10'(e);
    endfunction

    // Expected item list of one refresh; character items resolve against the model buffer when issued.
    task automatic push_refresh();
`ifdef LCD_TEXT_CLEAR_EN
        exp_q.push_back(32'h001);
`endif
        for (int l = 0; l < int'(LINES); l++) begin
            exp_q.push_back(32'h080 + ((l == 0) ? 0 : 32'h40));
            for (int c = 0; c < int'(COLS); c++) exp_q.push_back(DATA_TAG + l * int'(COLS) + c);
        end
    endtask

    // Monitor: compares every request against the queue and checks handshake rules.
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
        end else begin
            if (lcd_enable) begin
                pulses++;
                check_eq("en_back_to_back", 32'(prev_en), 0);
                check_eq("en_while_busy", 32'(lcd_busy), 0);
                check_eq("item_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    int e;
                    e = exp_q.pop_front();
                    check_eq("lcd_bus", 32'(lcd_bus), 32'(resolve(e)));
                end
            end else begin
                check_eq("bus_idle_zero", 32'(lcd_bus), 0);
            end
            if (done) begin
                dones++;
                check_eq("done_items_left", exp_q.size(), 0);
            end
            prev_en = lcd_enable;
        end
    end

    task automatic write_char(input int addr, input logic [7:0] ch);
        wr_en = 1'b1; wr_addr = 5'(addr); wr_data = ch; model_mem[addr] = ch;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic issue_start(input bit chk_latency);
        push_refresh();
        pulses = 0; dones = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_active", 32'(active), 1);
        check_eq("start_clears_error", 32'(error), 0);
        if (chk_latency) begin
            check_eq("latency_1", 32'(lcd_enable), 0);
            @(negedge clk);
            check_eq("latency_2", 32'(lcd_enable), 1);
        end
    endtask

    task automatic wait_done(input string tag, input bit poke_start);
        int n = 0;
        while (done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, 32'(done), 1);
        check_eq({tag, "_active_at_done"}, 32'(active), 0);
        if (poke_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_done_width"}, 32'(done), 0);
        check_eq({tag, "_pulses"}, pulses, N_ITEMS);
        check_eq({tag, "_done_count"}, dones, 1);
        check_eq({tag, "_queue_left"}, exp_q.size(), 0);
        if (poke_start) begin
            repeat (3) @(negedge clk);
            check_eq({tag, "_start_on_done_ignored"}, 32'(active), 0);
            check_eq({tag, "_no_new_pulses"}, pulses, N_ITEMS);
        end
    endtask

    initial begin
        int  seen;
        int  n;
        bit  early;
        logic [7:0] ch;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h20;

        repeat (3) @(negedge clk);
        check_eq("rst_outputs", 32'({lcd_enable, lcd_bus, active, done, error}), 0);
        rst = 1'b0;

        // HELLO during driver init; first request only after busy falls
        write_char(0, 8'h48); write_char(1, 8'h45); write_char(2, 8'h4C);
        write_char(3, 8'h4C); write_char(4, 8'h4F);
        issue_start(1'b0);
        wait_done("hello", 1'b1);

        // Random buffer contents
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 8; w++)
                write_char(int'($urandom_range(DEPTH - 1, 0)), 8'($urandom_range(8'h7E, 8'h21)));
            issue_start(1'b1);
            wait_done("rand", 1'b0);
        end

        // Extra start and a buffer write while item 5 is issued
        issue_start(1'b1);
        seen = 1; n = 0;
        while (seen < 6 && n < 500) begin
            @(negedge clk);
            n++;
            if (lcd_enable) seen++;
        end
        check_eq("mid_reached_item5", seen, 6);
        ch = ~model_mem[20];
        start = 1'b1; wr_en = 1'b1; wr_addr = 5'd20; wr_data = ch; model_mem[20] = ch;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        check_eq("mid_active", 32'(active), 1);
        wait_done("mid", 1'b0);

        // Driver never acknowledges
        no_ack = 1'b1;
        issue_start(1'b1);
        early = 1'b0;
        for (int j = 1; j < int'(ACK_TO); j++) begin
            @(negedge clk);
            if (error !== 1'b0 || active !== 1'b1) early = 1'b1;
        end
        check_eq("timeout_not_early", 32'(early), 0);
        @(negedge clk);
        check_eq("timeout_error", 32'(error), 1);
        check_eq("timeout_active", 32'(active), 0);
        repeat (3) @(negedge clk);
        check_eq("timeout_no_done", dones, 0);
        check_eq("timeout_error_sticky", 32'(error), 1);
        exp_q.delete();
        no_ack = 1'b0;
        issue_start(1'b1);
        wait_done("after_timeout", 1'b0);

        // Reset while waiting for the driver to finish an item
        fixed_hold = 4;
        issue_start(1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_outputs", 32'({lcd_enable, lcd_bus, active, done, error}), 0);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h20;
        fixed_hold = 0;
        issue_start(1'b0);
        wait_done("after_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
